pipe_control: RTL and testbench
===============================

Name: pipe_control

Overview:
- Pipelined successor to the single-cycle opcode decoder. Decodes the ID-stage opcode into the full control bundle and registers that bundle into the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles. Supports external flush and hold, and keeps a saturating stall counter for performance monitoring.
- Sits between the IF/ID register and the EX stage of the 5-stage CPU.

Parameters:
OPW, 11, opcode width (decode table is defined for 11).
RAW, 5, register-address width.
ZREG, 31, zero-register index; never participates in hazards.
CNTW, 16, stall-counter width.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
opCode_id  in  OPW  ID-stage opcode (instr[31:21])
valid_id  in  1  ID holds a real instruction
rn_id  in  RAW  instr[9:5]
rm_id  in  RAW  instr[20:16]
rt_id  in  RAW  instr[4:0]
flush  in  1  squash ID instruction (branch resolved taken)
hold  in  1  freeze ID/EX (downstream memory stall)
Reg2Loc_id  out  1  combinational, drives register-file read mux
stall_id  out  1  combinational, freeze PC and IF/ID
valid_ex, MemToReg_ex, BrTaken_ex, RegWriteEn_ex, MemWrite_ex, UncondBr_ex, shiftDir_ex, MemReadEn_ex, illegal_ex  out  1 each  registered controls
ALUOp_ex  out  2  registered
ALUSrc_ex  out  3  registered
rd_ex  out  RAW  registered rt_id (destination)
stall_cnt  out  CNTW  saturating load-use stall count

Behaviour:
- Decode (combinational). Every output defaults to 0 first; no latches.
- Decode match is first-match in this order; when nothing matches, all controls stay 0 and illegal=1.
  - R-type (1xxx1011000): Reg2Loc=1, RegWriteEn=1, ALUOp=10, ALUSrc=011 if op[7] else 000.
  - ADDI (1001000100x): Reg2Loc=1, RegWriteEn=1, ALUOp=10, ALUSrc=001.
  - Shift (1101001101x): Reg2Loc=1, RegWriteEn=1, ALUOp=10, ALUSrc=010, shiftDir=~op[0].
  - LDUR/STUR (111110000x0): Reg2Loc=0, ALUSrc=100, ALUOp=00. MemToReg, RegWriteEn and MemReadEn = op[1]; MemWrite=~op[1].
  - Branch (xxx101xxxxx): Reg2Loc=op[9], BrTaken=1, UncondBr=(op[10:9]==00), ALUOp=op[9:8], ALUSrc={UncondBr,00}.
- Source use:
  - rn is used by R-type, ADDI, shift, LDUR and STUR.
  - The second source is rm when Reg2Loc=1, else rt. It is used by R-type, STUR and CBZ (branch with op[10:9]=10).
  - Unconditional B and B.cond use no registers.
- Hazard: stall_id=1 when all of the following hold: valid_id, valid_ex, MemReadEn_ex, rd_ex!=ZREG, and rd_ex equals a used source.
  - stall_id is forced to 0 while flush=1.
- ID/EX update on the rising clk edge, priority highest first:
  1. flush=1: load a bubble (all registered outputs 0, rd_ex=0).
  2. hold=1: retain all registered values.
  3. stall_id=1: load a bubble.
  4. Otherwise: load the decoded bundle; valid_ex=valid_id, rd_ex=rt_id.
  - When valid_id=0, the decoded bundle is forced to a bubble (illegal suppressed).
  - Latency from ID inputs to _ex outputs is 1 cycle.
- stall_cnt: increments by 1 on each clock edge where stall_id=1 and hold=0. It saturates at all-ones and never wraps.
- Reset: reset_n low asynchronously clears every registered output and stall_cnt to 0. A reset asserted mid-stall drops the stall; after release, ID re-decodes from scratch.
- A load-use stall lasts exactly 1 cycle: the bubble clears MemReadEn_ex.
  - Exception: hold=1 keeps the stall asserted for as long as hold is high.

Test Plan:
- Reset: assert reset_n=0 mid-cycle -> all _ex outputs and stall_cnt read 0 immediately, with no clock edge.
- ADD 10001011000, then ADDI 10010001000, then LSL 11010011011 -> one cycle later each appears on the _ex outputs:
  - ADD: ALUSrc_ex=000, RegWriteEn_ex=1.
  - ADDI: ALUSrc_ex=001.
  - LSL: ALUSrc_ex=010, shiftDir_ex=0.
- Load-use: LDUR 11111000010 with rt=3, followed by ADD with rn=3 ->
  - stall_id=1 for one cycle, then a bubble (valid_ex=0) in EX.
  - ADD issues the next cycle; stall_cnt=1.
  - Repeating with rt=31 gives no stall.
- STUR after LDUR: STUR 11111000000 with rt=5 after LDUR with rd=5 -> stall (second source is rt because Reg2Loc=0). B 00010100000 after the same LDUR -> no stall.
- Flush and stall in the same cycle -> flush wins: bubble loaded, stall_id=0, stall_cnt unchanged.
- Hold during a stall for 3 cycles -> _ex values frozen, stall_cnt unchanged.
- Illegal opcode 00000000000 with valid_id=1 -> illegal_ex=1 and all other controls 0.
- stall_cnt saturation: force CNTW=2 and run 5 stalls -> stall_cnt stays at 3.

Source files
------------

// File: rtl/pipe_control.sv
// -----------------------------------------------------------------------------
// pipe_control
//   ID-stage control unit of the 5-stage CPU. Decodes the ID opcode into the
//   full control bundle, detects load-use hazards against the instruction in
//   EX, and registers the bundle into the ID/EX pipeline register. Flush and
//   hold from outside the block override the normal update. A saturating
//   counter tracks how many cycles were lost to load-use stalls.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   opCode_id      ID opcode (instr[31:21])
//   valid_id       ID holds a real instruction
//   rn_id/rm_id/rt_id  register fields of the ID instruction
//   flush          squash the ID instruction (taken branch resolved)
//   hold           freeze ID/EX (downstream memory stall)
//   Reg2Loc_id     combinational register-file read-mux select
//   stall_id       combinational freeze of PC and IF/ID
//   *_ex           registered control bundle in EX
//   rd_ex          registered destination register (rt of the ID instruction)
//   stall_cnt      saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module pipe_control #(
  parameter int OPW  = 11,
  parameter int RAW  = 5,
  parameter int ZREG = 31,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OPW-1:0]  opCode_id,
  input  logic            valid_id,
  input  logic [RAW-1:0]  rn_id,
  input  logic [RAW-1:0]  rm_id,
  input  logic [RAW-1:0]  rt_id,
  input  logic            flush,
  input  logic            hold,
  output logic            Reg2Loc_id,
  output logic            stall_id,
  output logic            valid_ex,
  output logic            MemToReg_ex,
  output logic            BrTaken_ex,
  output logic            RegWriteEn_ex,
  output logic            MemWrite_ex,
  output logic            UncondBr_ex,
  output logic            shiftDir_ex,
  output logic            MemReadEn_ex,
  output logic            illegal_ex,
  output logic [1:0]      ALUOp_ex,
  output logic [2:0]      ALUSrc_ex,
  output logic [RAW-1:0]  rd_ex,
  output logic [CNTW-1:0] stall_cnt
);

  typedef struct packed {
    logic           valid;
    logic           mem_to_reg;
    logic           br_taken;
    logic           reg_write;
    logic           mem_write;
    logic           uncond_br;
    logic           shift_dir;
    logic           mem_read;
    logic           illegal;
    logic [1:0]     alu_op;
    logic [2:0]     alu_src;
    logic [RAW-1:0] rd;
  } ex_bundle_t;

  logic [10:0]     op;
  ex_bundle_t      dec;
  logic            dec_reg2loc;
  logic            use_rn;
  logic            use_s2;
  logic [RAW-1:0]  src2;
  logic            src_hit;
  logic            stall;

  ex_bundle_t      ex_d, ex_q;
  logic [CNTW-1:0] cnt_d, cnt_q;

  assign op = opCode_id[10:0];

  // ---- ID stage: decode ----------------------------------------------------
  always_comb begin
    dec         = '0;
    dec_reg2loc = 1'b0;
    use_rn      = 1'b0;
    use_s2      = 1'b0;
    casez (op)
      11'b1???1011000: begin  // R-type; op[7] picks the alternate operand path
        dec_reg2loc   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        dec.alu_src   = op[7] ? 3'b011 : 3'b000;
        use_rn        = 1'b1;
        use_s2        = 1'b1;
      end
      11'b1001000100?: begin  // ADDI
        dec_reg2loc   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        dec.alu_src   = 3'b001;
        use_rn        = 1'b1;
      end
      11'b1101001101?: begin  // LSL/LSR; op[0]=1 is LSL (shift left -> dir 0)
        dec_reg2loc   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
        dec.alu_src   = 3'b010;
        dec.shift_dir = ~op[0];
        use_rn        = 1'b1;
      end
      11'b111110000?0: begin  // LDUR (op[1]=1) / STUR (op[1]=0)
        dec.alu_src    = 3'b100;
        dec.mem_to_reg = op[1];
        dec.reg_write  = op[1];
        dec.mem_read   = op[1];
        dec.mem_write  = ~op[1];
        use_rn         = 1'b1;
        use_s2         = ~op[1];  // STUR reads the store data through rt
      end
      11'b???101?????: begin  // branches; op[10:9]=00 is B, 10 is CBZ
        dec_reg2loc   = op[9];
        dec.br_taken  = 1'b1;
        dec.uncond_br = (op[10:9] == 2'b00);
        dec.alu_op    = op[9:8];
        dec.alu_src   = {(op[10:9] == 2'b00), 2'b00};
        use_s2        = (op[10:9] == 2'b10);
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.valid = 1'b1;
    dec.rd    = rt_id;
    if (!valid_id) begin
      dec = '0;
    end
  end

  assign Reg2Loc_id = dec_reg2loc;

  // Load-use hazard: EX holds a load whose destination feeds an ID source.
  always_comb begin
    src2    = dec_reg2loc ? rm_id : rt_id;
    src_hit = (use_rn && (rn_id == ex_q.rd)) || (use_s2 && (src2 == ex_q.rd));
    stall   = ~flush & valid_id & ex_q.valid & ex_q.mem_read &
              (ex_q.rd != RAW'(ZREG)) & src_hit;
  end

  assign stall_id = stall;

  // ---- ID/EX boundary ------------------------------------------------------
  always_comb begin
    ex_d = dec;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (stall) begin
      ex_d = '0;
    end
  end

  // A held stall is the same lost cycle, so it is counted once on release.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && !hold && !(&cnt_q)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  // ---- EX stage outputs ----------------------------------------------------
  assign valid_ex      = ex_q.valid;
  assign MemToReg_ex   = ex_q.mem_to_reg;
  assign BrTaken_ex    = ex_q.br_taken;
  assign RegWriteEn_ex = ex_q.reg_write;
  assign MemWrite_ex   = ex_q.mem_write;
  assign UncondBr_ex   = ex_q.uncond_br;
  assign shiftDir_ex   = ex_q.shift_dir;
  assign MemReadEn_ex  = ex_q.mem_read;
  assign illegal_ex    = ex_q.illegal;
  assign ALUOp_ex      = ex_q.alu_op;
  assign ALUSrc_ex     = ex_q.alu_src;
  assign rd_ex         = ex_q.rd;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// -----------------------------------------------------------------------------
// tb_pipe_control
//   Self-checking bench for pipe_control. A behavioural model built from the
//   opcode table (mask/value matching) and the hazard rules predicts stall_id,
//   Reg2Loc_id, the EX bundle and both stall counters. A second instance with a
//   2-bit counter shares all inputs to observe saturation.
// -----------------------------------------------------------------------------
module tb_pipe_control;

  typedef struct packed {
    logic       valid;
    logic       mem_to_reg;
    logic       br_taken;
    logic       reg_write;
    logic       mem_write;
    logic       uncond;
    logic       shift_dir;
    logic       mem_read;
    logic       illegal;
    logic [1:0] alu_op;
    logic [2:0] alu_src;
    logic [4:0] rd;
  } ctl_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDX = 11'b10011011000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_ILL  = 11'b00000000000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] opCode_id;
  logic        valid_id, flush, hold;
  logic [4:0]  rn_id, rm_id, rt_id;
  logic        Reg2Loc_id, stall_id;
  logic        valid_ex, MemToReg_ex, BrTaken_ex, RegWriteEn_ex, MemWrite_ex;
  logic        UncondBr_ex, shiftDir_ex, MemReadEn_ex, illegal_ex;
  logic [1:0]  ALUOp_ex;
  logic [2:0]  ALUSrc_ex;
  logic [4:0]  rd_ex;
  logic [15:0] stall_cnt;

  logic        r2l_b, stall_b, valid_b, m2r_b, br_b, rw_b, mw_b, ub_b, sd_b, mr_b, ill_b;
  logic [1:0]  aluop_b;
  logic [2:0]  alusrc_b;
  logic [4:0]  rd_b;
  logic [1:0]  stall_cnt2;

  ctl_t got_ex;
  ctl_t m_ex;
  int   m_cnt, m_cnt2;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  assign got_ex = {valid_ex, MemToReg_ex, BrTaken_ex, RegWriteEn_ex, MemWrite_ex,
                   UncondBr_ex, shiftDir_ex, MemReadEn_ex, illegal_ex,
                   ALUOp_ex, ALUSrc_ex, rd_ex};

  pipe_control dut (
    .clk(clk), .reset_n(reset_n), .opCode_id(opCode_id), .valid_id(valid_id),
    .rn_id(rn_id), .rm_id(rm_id), .rt_id(rt_id), .flush(flush), .hold(hold),
    .Reg2Loc_id(Reg2Loc_id), .stall_id(stall_id), .valid_ex(valid_ex),
    .MemToReg_ex(MemToReg_ex), .BrTaken_ex(BrTaken_ex), .RegWriteEn_ex(RegWriteEn_ex),
    .MemWrite_ex(MemWrite_ex), .UncondBr_ex(UncondBr_ex), .shiftDir_ex(shiftDir_ex),
    .MemReadEn_ex(MemReadEn_ex), .illegal_ex(illegal_ex), .ALUOp_ex(ALUOp_ex),
    .ALUSrc_ex(ALUSrc_ex), .rd_ex(rd_ex), .stall_cnt(stall_cnt)
  );

  pipe_control #(.CNTW(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .opCode_id(opCode_id), .valid_id(valid_id),
    .rn_id(rn_id), .rm_id(rm_id), .rt_id(rt_id), .flush(flush), .hold(hold),
    .Reg2Loc_id(r2l_b), .stall_id(stall_b), .valid_ex(valid_b),
    .MemToReg_ex(m2r_b), .BrTaken_ex(br_b), .RegWriteEn_ex(rw_b),
    .MemWrite_ex(mw_b), .UncondBr_ex(ub_b), .shiftDir_ex(sd_b),
    .MemReadEn_ex(mr_b), .illegal_ex(ill_b), .ALUOp_ex(aluop_b),
    .ALUSrc_ex(alusrc_b), .rd_ex(rd_b), .stall_cnt(stall_cnt2)
  );

  // ---------------- reference model ----------------
  // Instruction class from the opcode table, first match wins:
  // 0 R-type, 1 ADDI, 2 shift, 3 load/store, 4 branch, 5 illegal.
  function automatic int classify(input logic [10:0] op);
    logic [10:0] mask [5];
    logic [10:0] val  [5];
    mask[0] = 11'b10001111111; val[0] = 11'b10001011000;
    mask[1] = 11'b11111111110; val[1] = 11'b10010001000;
    mask[2] = 11'b11111111110; val[2] = 11'b11010011010;
    mask[3] = 11'b11111111101; val[3] = 11'b11111000000;
    mask[4] = 11'b00011100000; val[4] = 11'b00010100000;
    for (int i = 0; i < 5; i++)
      if ((op & mask[i]) == val[i]) return i;
    return 5;
  endfunction

  function automatic logic ref_r2l(input logic [10:0] op);
    int k = classify(op);
    if (k <= 2) return 1'b1;
    if (k == 4) return op[9];
    return 1'b0;
  endfunction

  function automatic ctl_t ref_bundle(input logic [10:0] op, input logic v, input logic [4:0] rt);
    ctl_t c = '0;
    int   k = classify(op);
    if (!v) return c;
    c.valid = 1'b1;
    c.rd    = rt;
    case (k)
      0: begin c.reg_write = 1; c.alu_op = 2'd2; c.alu_src = op[7] ? 3'd3 : 3'd0; end
      1: begin c.reg_write = 1; c.alu_op = 2'd2; c.alu_src = 3'd1; end
      2: begin c.reg_write = 1; c.alu_op = 2'd2; c.alu_src = 3'd2; c.shift_dir = !op[0]; end
      3: begin
        c.alu_src = 3'd4; c.mem_to_reg = op[1]; c.reg_write = op[1];
        c.mem_read = op[1]; c.mem_write = !op[1];
      end
      4: begin
        c.br_taken = 1; c.uncond = (op[10:9] == 2'b00); c.alu_op = op[9:8];
        c.alu_src = c.uncond ? 3'd4 : 3'd0;
      end
      default: c.illegal = 1;
    endcase
    return c;
  endfunction

  function automatic logic ref_stall(input logic [10:0] op, input logic v,
                                     input logic [4:0] rn, input logic [4:0] rm,
                                     input logic [4:0] rt, input logic fl);
    int         k       = classify(op);
    logic [4:0] s2      = ref_r2l(op) ? rm : rt;
    logic       rn_used = (k <= 3);
    logic       s2_used = (k == 0) || (k == 3 && !op[1]) || (k == 4 && op[10:9] == 2'b10);
    if (fl || !v || !m_ex.valid || !m_ex.mem_read || m_ex.rd == 5'd31) return 1'b0;
    return (rn_used && rn == m_ex.rd) || (s2_used && s2 == m_ex.rd);
  endfunction

  // Drives one ID cycle, samples the combinational outputs mid-cycle, clocks,
  // advances the model, and returns 1 time unit after the edge.
  task automatic drive_cycle(input logic [10:0] op, input logic v,
                             input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rt,
                             input logic fl, input logic hd,
                             output logic got_st, output logic exp_st,
                             output logic got_r2l, output logic exp_r2l);
    opCode_id = op; valid_id = v; rn_id = rn; rm_id = rm; rt_id = rt;
    flush = fl; hold = hd;
    #1;
    got_st  = stall_id;
    got_r2l = Reg2Loc_id;
    exp_st  = ref_stall(op, v, rn, rm, rt, fl);
    exp_r2l = ref_r2l(op);
    @(posedge clk);
    if (exp_st && !hd) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (fl)          m_ex = '0;
    else if (hd)     m_ex = m_ex;
    else if (exp_st) m_ex = '0;
    else             m_ex = ref_bundle(op, v, rt);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0; opCode_id = '0; valid_id = 0; rn_id = '0; rm_id = '0; rt_id = '0;
    flush = 0; hold = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    m_ex = '0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic gs, es, gr, er;
    do_reset();
    drive_cycle(OP_LDUR, 1, 5'd1, 5'd2, 5'd3, 0, 0, gs, es, gr, er);
    drive_cycle(OP_ADD,  1, 5'd3, 5'd7, 5'd8, 0, 0, gs, es, gr, er);
    drive_cycle(OP_LDUR, 1, 5'd1, 5'd2, 5'd4, 0, 0, gs, es, gr, er);
    n_tests++;
    if (stall_cnt !== 16'd1 || valid_ex !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre: cnt=%0d valid_ex=%b required cnt=1 valid_ex=1", stall_cnt, valid_ex);
    end
    #2 reset_n = 0;
    #1;
    n_tests++;
    if (got_ex !== '0 || stall_cnt !== '0 || stall_cnt2 !== '0) begin
      n_fail++; $display("FAIL reset_async: ex=%h cnt=%0d cnt2=%0d required all 0", got_ex, stall_cnt, stall_cnt2);
    end
    valid_id = 0;
    @(posedge clk);
    #1 reset_n = 1;
    m_ex = '0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic test_alu_decode();
    logic gs, es, gr, er;
    do_reset();
    drive_cycle(OP_ADD, 1, 5'd1, 5'd2, 5'd10, 0, 0, gs, es, gr, er);
    n_tests++;
    if (ALUSrc_ex !== 3'b000 || RegWriteEn_ex !== 1'b1 || got_ex !== m_ex) begin
      n_fail++; $display("FAIL add_decode: ex=%h required %h (ALUSrc 000, RegWriteEn 1)", got_ex, m_ex);
    end
    n_tests++;
    if (gr !== 1'b1) begin
      n_fail++; $display("FAIL add_reg2loc: got %b required 1", gr);
    end
    drive_cycle(OP_ADDI, 1, 5'd1, 5'd2, 5'd11, 0, 0, gs, es, gr, er);
    n_tests++;
    if (ALUSrc_ex !== 3'b001 || rd_ex !== 5'd11 || got_ex !== m_ex) begin
      n_fail++; $display("FAIL addi_decode: ex=%h required %h (ALUSrc 001)", got_ex, m_ex);
    end
    drive_cycle(OP_LSL, 1, 5'd1, 5'd2, 5'd12, 0, 0, gs, es, gr, er);
    n_tests++;
    if (ALUSrc_ex !== 3'b010 || shiftDir_ex !== 1'b0 || got_ex !== m_ex) begin
      n_fail++; $display("FAIL lsl_decode: ex=%h required %h (ALUSrc 010, shiftDir 0)", got_ex, m_ex);
    end
  endtask

  task automatic test_load_use();
    logic gs, es, gr, er;
    do_reset();
    drive_cycle(OP_LDUR, 1, 5'd1, 5'd2, 5'd3, 0, 0, gs, es, gr, er);
    drive_cycle(OP_ADD,  1, 5'd3, 5'd7, 5'd8, 0, 0, gs, es, gr, er);
    n_tests++;
    if (gs !== 1'b1 || valid_ex !== 1'b0) begin
      n_fail++; $display("FAIL load_use_stall: stall=%b valid_ex=%b required stall=1 valid_ex=0", gs, valid_ex);
    end
    drive_cycle(OP_ADD,  1, 5'd3, 5'd7, 5'd8, 0, 0, gs, es, gr, er);
    n_tests++;
    if (gs !== 1'b0 || valid_ex !== 1'b1 || RegWriteEn_ex !== 1'b1 || rd_ex !== 5'd8 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL load_use_issue: stall=%b valid_ex=%b rd=%0d cnt=%0d required 0 1 8 1", gs, valid_ex, rd_ex, stall_cnt);
    end
    drive_cycle(OP_LDUR, 1, 5'd1, 5'd2, 5'd31, 0, 0, gs, es, gr, er);
    drive_cycle(OP_ADD,  1, 5'd31, 5'd31, 5'd8, 0, 0, gs, es, gr, er);
    n_tests++;
    if (gs !== 1'b0 || valid_ex !== 1'b1 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL zreg_no_stall: stall=%b valid_ex=%b cnt=%0d required 0 1 1", gs, valid_ex, stall_cnt);
    end
  endtask

  task automatic test_stur_branch();
    logic gs, es, gr, er;
    do_reset();
    drive_cycle(OP_LDUR, 1, 5'd1, 5'd2, 5'd5, 0, 0, gs, es, gr, er);
    drive_cycle(OP_STUR, 1, 5'd1, 5'd9, 5'd5, 0, 0, gs, es, gr, er);
    n_tests++;
    if (gs !== 1'b1 || gr !== 1'b0 || valid_ex !== 1'b0) begin
      n_fail++; $display("FAIL stur_stall: stall=%b r2l=%b valid_ex=%b required 1 0 0", gs, gr, valid_ex);
    end
    drive_cycle(OP_LDUR, 1, 5'd1, 5'd2, 5'd5, 0, 0, gs, es, gr, er);
    drive_cycle(OP_B,    1, 5'd5, 5'd5, 5'd5, 0, 0, gs, es, gr, er);
    n_tests++;
    if (gs !== 1'b0 || BrTaken_ex !== 1'b1 || UncondBr_ex !== 1'b1 || ALUSrc_ex !== 3'b100 || got_ex !== m_ex) begin
      n_fail++; $display("FAIL branch_no_stall: stall=%b ex=%h required stall 0 ex %h", gs, got_ex, m_ex);
    end
  endtask

  task automatic test_flush();
    logic gs, es, gr, er;
    do_reset();
    drive_cycle(OP_LDUR, 1, 5'd1, 5'd2, 5'd3, 0, 0, gs, es, gr, er);
    drive_cycle(OP_ADD,  1, 5'd3, 5'd7, 5'd8, 1, 0, gs, es, gr, er);
    n_tests++;
    if (gs !== 1'b0 || got_ex !== '0 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL flush_wins: stall=%b ex=%h cnt=%0d required 0 0 0", gs, got_ex, stall_cnt);
    end
  endtask

  task automatic test_hold();
    logic gs, es, gr, er;
    ctl_t ld;
    do_reset();
    drive_cycle(OP_LDUR, 1, 5'd1, 5'd2, 5'd3, 0, 0, gs, es, gr, er);
    ld = got_ex;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(OP_ADD, 1, 5'd3, 5'd7, 5'd8, 0, 1, gs, es, gr, er);
      n_tests++;
      if (gs !== 1'b1 || got_ex !== ld || MemReadEn_ex !== 1'b1 || rd_ex !== 5'd3 || stall_cnt !== 16'd0) begin
        n_fail++; $display("FAIL hold_freeze[%0d]: stall=%b ex=%h cnt=%0d required 1 %h 0", i, gs, got_ex, stall_cnt, ld);
      end
    end
    drive_cycle(OP_ADD, 1, 5'd3, 5'd7, 5'd8, 0, 0, gs, es, gr, er);
    n_tests++;
    if (gs !== 1'b1 || valid_ex !== 1'b0 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL hold_release: stall=%b valid_ex=%b cnt=%0d required 1 0 1", gs, valid_ex, stall_cnt);
    end
  endtask

  task automatic test_illegal();
    logic gs, es, gr, er;
    do_reset();
    drive_cycle(OP_ILL, 1, 5'd1, 5'd2, 5'd9, 0, 0, gs, es, gr, er);
    n_tests++;
    if (illegal_ex !== 1'b1 || valid_ex !== 1'b1 || gr !== 1'b0 ||
        {MemToReg_ex, BrTaken_ex, RegWriteEn_ex, MemWrite_ex, UncondBr_ex,
         shiftDir_ex, MemReadEn_ex, ALUOp_ex, ALUSrc_ex} !== 12'd0) begin
      n_fail++; $display("FAIL illegal_decode: ex=%h r2l=%b required illegal only", got_ex, gr);
    end
  endtask

  task automatic test_saturation();
    logic gs, es, gr, er;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(OP_LDUR, 1, 5'd1, 5'd2, 5'd3, 0, 0, gs, es, gr, er);
      drive_cycle(OP_ADD,  1, 5'd3, 5'd7, 5'd8, 0, 0, gs, es, gr, er);
    end
    n_tests++;
    if (stall_cnt2 !== 2'd3 || stall_cnt !== 16'd5) begin
      n_fail++; $display("FAIL cnt_saturate: cnt2=%0d cnt=%0d required 3 5", stall_cnt2, stall_cnt);
    end
  endtask

  task automatic test_random();
    logic gs, es, gr, er;
    logic [10:0] op;
    logic [4:0]  r [3];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 8))
        0: op = OP_ADD;
        1: op = OP_ADDX;
        2: op = OP_ADDI;
        3: op = ($urandom_range(0, 1) != 0) ? OP_LSL : OP_LSR;
        4, 5: op = OP_LDUR;
        6: op = OP_STUR;
        7: op = {3'($urandom), 3'b101, 5'($urandom)};
        default: op = 11'($urandom);
      endcase
      for (int j = 0; j < 3; j++)
        r[j] = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      drive_cycle(op, $urandom_range(0, 7) != 0, r[0], r[1], r[2],
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, gs, es, gr, er);
      n_tests++;
      if (gs !== es || gr !== er) begin
        n_fail++; $display("FAIL rand_comb[%0d]: stall=%b r2l=%b required %b %b op=%b", c, gs, gr, es, er, op);
      end
      n_tests++;
      if (got_ex !== m_ex || stall_cnt !== 16'(m_cnt) || stall_cnt2 !== 2'(m_cnt2)) begin
        n_fail++; $display("FAIL rand_ex[%0d]: ex=%h cnt=%0d cnt2=%0d required %h %0d %0d",
                           c, got_ex, stall_cnt, stall_cnt2, m_ex, m_cnt, m_cnt2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_decode();
    test_load_use();
    test_stur_branch();
    test_flush();
    test_hold();
    test_illegal();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
